// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt controller: source numbering,
// default bus addresses and the vector helper.
package interrupt_pkg;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_src_e;

    localparam int          NUM_IRQ      = 5;
    localparam logic [15:0] IF_ADDR_C    = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_C    = 16'hFFFF;
    localparam logic [7:0]  IRQ_VEC_BASE = 8'h40;

    // Vectors are spaced 8 bytes apart, starting at the base.
    function automatic logic [7:0] irq_vec(input logic [2:0] idx,
                                           input logic [7:0] base = IRQ_VEC_BASE);
        return base + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus and CPU handshake signals of the interrupt controller.
// The master is the CPU/bus side; the slave is the controller.
interface interrupt_controller_if;

    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_rdata;
    logic        bus_hit;
    logic        irq_pending;
    logic [2:0]  irq_index;
    logic [7:0]  irq_vector;
    logic        irq_ack;

    modport master (
        output bus_addr, bus_wdata, bus_read, bus_write, irq_ack,
        input  bus_rdata, bus_hit, irq_pending, irq_index, irq_vector
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_read, bus_write, irq_ack,
        output bus_rdata, bus_hit, irq_pending, irq_index, irq_vector
    );

endinterface

// File: rtl/irq_priority_enc.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
module irq_priority_enc
    import interrupt_pkg::*;
#(
    parameter int NUM_SRC = NUM_IRQ
) (
    input  logic [NUM_SRC-1:0] pend,
    output logic               valid,
    output logic [2:0]         index
);

    // Scanning from the top down lets the lowest set bit overwrite the others.
    always_comb begin
        valid = |pend;
        index = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend[i]) index = 3'(i);
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt source block: edge-latches peripheral requests into IF, masks with IE,
// presents the winning vector to the CPU and serves IF/IE on the bus.
// Optional macro IRQ_LOST_CNT_EN adds a saturating lost-edge counter output.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int          NUM_SRC  = NUM_IRQ,
    parameter logic [15:0] IF_ADDR  = IF_ADDR_C,
    parameter logic [15:0] IE_ADDR  = IE_ADDR_C,
    parameter logic [7:0]  VEC_BASE = IRQ_VEC_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    interrupt_controller_if.slave bus
`ifdef IRQ_LOST_CNT_EN
    ,
    output logic [7:0]         irq_lost_cnt
`endif
);

    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] if_q;
    logic [NUM_SRC-1:0] if_next;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_mask;
    logic [NUM_SRC-1:0] pend;
    logic [7:0]         ie_q;
    logic [7:0]         rd_mux;
    logic [7:0]         rdata_q;
    logic               hit_q;
    logic               pending_q;
    logic [2:0]         index_q;
    logic [7:0]         vector_q;
    logic               enc_valid;
    logic [2:0]         enc_index;
    logic               if_sel;
    logic               ie_sel;

    assign if_sel = (bus.bus_addr == IF_ADDR);
    assign ie_sel = (bus.bus_addr == IE_ADDR);
    assign rise   = irq_req & ~req_q;
    assign pend   = if_q & ie_q[NUM_SRC-1:0];

    // Bus write first, then the ack clear, then new edges, so an edge always wins.
    always_comb begin
        ack_mask = '0;
        if (bus.irq_ack && pending_q) ack_mask = NUM_SRC'(1) << index_q;
        if_next = if_q;
        if (bus.bus_write && if_sel) if_next = bus.bus_wdata[NUM_SRC-1:0];
        if_next = (if_next & ~ack_mask) | rise;
    end

    always_comb begin
        rd_mux = 8'hFF;
        if (if_sel)      rd_mux[NUM_SRC-1:0] = if_q;
        else if (ie_sel) rd_mux = ie_q;
    end

    irq_priority_enc #(.NUM_SRC(NUM_SRC)) u_enc (
        .pend  (pend),
        .valid (enc_valid),
        .index (enc_index)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q     <= '0;
            if_q      <= '0;
            ie_q      <= 8'h00;
            rdata_q   <= 8'hFF;
            hit_q     <= 1'b0;
            pending_q <= 1'b0;
            index_q   <= 3'd0;
            vector_q  <= VEC_BASE;
        end else begin
            req_q     <= irq_req;
            if_q      <= if_next;
            if (bus.bus_write && ie_sel) ie_q <= bus.bus_wdata;
            rdata_q   <= bus.bus_read ? rd_mux : 8'hFF;
            hit_q     <= (bus.bus_read || bus.bus_write) && (if_sel || ie_sel);
            pending_q <= enc_valid;
            index_q   <= enc_index;
            vector_q  <= irq_vec(enc_index, VEC_BASE);
        end
    end

    assign bus.bus_rdata   = rdata_q;
    assign bus.bus_hit     = hit_q;
    assign bus.irq_pending = pending_q;
    assign bus.irq_index   = index_q;
    assign bus.irq_vector  = vector_q;

`ifdef IRQ_LOST_CNT_EN
    logic [7:0] lost_q;

    // One count per cycle in which an edge lands on an already-set IF bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lost_q <= 8'h00;
        end else if (bus.bus_write && if_sel) begin
            lost_q <= 8'h00;
        end else if (|(rise & if_q) && lost_q != 8'hFF) begin
            lost_q <= lost_q + 8'h01;
        end
    end

    assign irq_lost_cnt = lost_q;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scoreboard bench for interrupt_controller; expectations are queued as
// stimulus is driven and compared after the clock edge that produces them.
module tb_interrupt_controller;

    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;

    localparam int SEL_RDATA = 0;
    localparam int SEL_HIT   = 1;
    localparam int SEL_PEND  = 2;
    localparam int SEL_INDEX = 3;
    localparam int SEL_VEC   = 4;
    localparam int SEL_LOST  = 5;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] value;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [4:0] irq_req;
    exp_t       sbq[$];
    int         compared;
    int         mismatched;

    interrupt_controller_if ifc ();

`ifdef IRQ_LOST_CNT_EN
    logic [7:0] irq_lost_cnt;
`endif

    interrupt_controller dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .bus          (ifc)
`ifdef IRQ_LOST_CNT_EN
        ,
        .irq_lost_cnt (irq_lost_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input int sel, input logic [7:0] value);
        exp_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        sbq.push_back(e);
    endtask

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            SEL_RDATA: return ifc.bus_rdata;
            SEL_HIT:   return {7'b0, ifc.bus_hit};
            SEL_PEND:  return {7'b0, ifc.irq_pending};
            SEL_INDEX: return {5'b0, ifc.irq_index};
            SEL_VEC:   return ifc.irq_vector;
`ifdef IRQ_LOST_CNT_EN
            SEL_LOST:  return irq_lost_cnt;
`endif
            default:   return 8'hxx;
        endcase
    endfunction

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sel);
            compared++;
            assert (obs === e.value)
            else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%02h expected=%02h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic expectIrq(input string tag, input logic pend, input logic [2:0] idx,
                             input logic [7:0] vec);
        expectOut({tag, "_pend"}, SEL_PEND, {7'b0, pend});
        expectOut({tag, "_idx"}, SEL_INDEX, {5'b0, idx});
        expectOut({tag, "_vec"}, SEL_VEC, vec);
    endtask

    // Drives request levels and a one-cycle ack, then releases the ack.
    task automatic applyStimulus(input logic [4:0] req, input logic ack);
        irq_req     = req;
        ifc.irq_ack = ack;
        tick();
        ifc.irq_ack = 1'b0;
    endtask

    task automatic busRead(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        ifc.bus_addr = addr;
        ifc.bus_read = 1'b1;
        expectOut({tag, "_rdata"}, SEL_RDATA, exp);
        expectOut({tag, "_hit"}, SEL_HIT, {7'b0, (addr == IF_A) || (addr == IE_A)});
        tick();
        ifc.bus_read = 1'b0;
        checkOutput();
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
        ifc.bus_addr  = addr;
        ifc.bus_wdata = data;
        ifc.bus_write = 1'b1;
        tick();
        ifc.bus_write = 1'b0;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b0;
        irq_req       = '0;
        ifc.bus_addr  = '0;
        ifc.bus_wdata = '0;
        ifc.bus_read  = 1'b0;
        ifc.bus_write = 1'b0;
        ifc.irq_ack   = 1'b0;

        repeat (3) tick();
        expectOut("rst_rdata", SEL_RDATA, 8'hFF);
        expectOut("rst_hit", SEL_HIT, 8'h00);
        expectIrq("rst", 1'b0, 3'd0, 8'h40);
`ifdef IRQ_LOST_CNT_EN
        expectOut("rst_lost", SEL_LOST, 8'h00);
`endif
        checkOutput();
        reset = 1'b1;
        tick();

        $display("[TB] reset and idle reads");
        busRead("t1_if", IF_A, 8'hE0);
        busRead("t1_ie", IE_A, 8'h00);
        busRead("t1_miss", 16'h1234, 8'hFF);

        $display("[TB] single request, ack");
        busWrite(IE_A, 8'h1F);
        busRead("t2_ie", IE_A, 8'h1F);
        applyStimulus(5'b00100, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t2_raise", 1'b1, 3'd2, 8'h50);
        checkOutput();
        applyStimulus(5'b00000, 1'b1);
        expectOut("t2_cleared_pend", SEL_PEND, 8'h00);
        busRead("t2_if", IF_A, 8'hE0);

        $display("[TB] simultaneous requests, priority");
        applyStimulus(5'b10001, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t3_first", 1'b1, 3'd0, 8'h40);
        checkOutput();
        applyStimulus(5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t3_second", 1'b1, 3'd4, 8'h60);
        checkOutput();
        applyStimulus(5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b0);
        expectOut("t3_done_pend", SEL_PEND, 8'h00);
        checkOutput();

        $display("[TB] ack collides with new edge");
        applyStimulus(5'b00010, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t4_pre", 1'b1, 3'd1, 8'h48);
        checkOutput();
        applyStimulus(5'b00010, 1'b1);
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t4_kept", 1'b1, 3'd1, 8'h48);
        checkOutput();
        busRead("t4_if", IF_A, 8'hE2);
        applyStimulus(5'b00000, 1'b1);
        applyStimulus(5'b00000, 1'b0);
        expectOut("t4_done_pend", SEL_PEND, 8'h00);
        checkOutput();

        $display("[TB] bus write of IF with ack on another bit");
        busWrite(IF_A, 8'h06);
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t4b_pre", 1'b1, 3'd1, 8'h48);
        checkOutput();
        ifc.irq_ack = 1'b1;
        busWrite(IF_A, 8'h0A);
        ifc.irq_ack = 1'b0;
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t4b_post", 1'b1, 3'd3, 8'h58);
        checkOutput();
        busRead("t4b_if", IF_A, 8'hE8);
        busWrite(IF_A, 8'h00);

        $display("[TB] masked request, late enable");
        busWrite(IE_A, 8'h00);
        applyStimulus(5'b01000, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        expectOut("t5_masked_pend", SEL_PEND, 8'h00);
        checkOutput();
        busRead("t5_if", IF_A, 8'hE8);
        busWrite(IE_A, 8'h08);
        expectOut("t5_write_edge_pend", SEL_PEND, 8'h00);
        checkOutput();
        applyStimulus(5'b00000, 1'b0);
        expectIrq("t5_enabled", 1'b1, 3'd3, 8'h58);
        checkOutput();

        $display("[TB] reset mid-handshake");
        ifc.irq_ack = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        expectIrq("rst2", 1'b0, 3'd0, 8'h40);
        expectOut("rst2_rdata", SEL_RDATA, 8'hFF);
        checkOutput();
        tick();
        ifc.irq_ack = 1'b0;
        reset = 1'b1;
        tick();
        busRead("rst2_if", IF_A, 8'hE0);
        busRead("rst2_ie", IE_A, 8'h00);

`ifdef IRQ_LOST_CNT_EN
        $display("[TB] lost edge counter");
        applyStimulus(5'b00001, 1'b0);
        applyStimulus(5'b00000, 1'b0);
        expectOut("t6_zero", SEL_LOST, 8'h00);
        checkOutput();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(5'b00001, 1'b0);
            applyStimulus(5'b00000, 1'b0);
        end
        expectOut("t6_sat", SEL_LOST, 8'hFF);
        checkOutput();
        busWrite(IF_A, 8'h00);
        expectOut("t6_clear", SEL_LOST, 8'h00);
        checkOutput();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
